if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the ID-stage decoder. Issues sequential PC fetches to a
//  1-cycle synchronous instruction BRAM and buffers returned words in a DEPTH-entry FIFO.
//  Presents one {instr, PC} per cycle to decode, with Op/Fn3/Fn7 pre-sliced for the decoder.
//  Absorbs ID stalls and discards wrong-path words on branch/jump redirects.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk         in   1   CPU clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  StallD      in   1   decode holds current instruction; no dequeue
//  RedirectE   in   1   taken branch / jal / jalr resolved; flush and refetch
//  RedirectPC  in   32  target PC when RedirectE=1
//  IMemAddr    out  32  BRAM word address (byte PC)
//  IMemRd      out  1   read request this cycle; data returns next cycle
//  IMemData    in   32  BRAM read data, valid cycle after IMemRd
//  ValidD      out  1   InstrD/PCD hold a real instruction
//  InstrD      out  32  head instruction; `NOP_INSTR when ValidD=0
//  PCD         out  32  PC of InstrD
//  OpD/Fn3D/Fn7D out 7/3/7  InstrD[6:0], [14:12], [31:25]
// BEHAVIOUR
//  Reset: FetchPC=RESET_PC, count=0, inflight=0, epoch=0, ValidD=0, InstrD=`NOP_INSTR, PCD=0,
//   IMemRd=0. First IMemRd in the first cycle after rst deasserts.
//  Credit: IMemRd=1 iff !RedirectE && (count + inflight - deq) < DEPTH; deq = ValidD && !StallD.
//   On issue: FetchPC += 4, inflight=1, request tagged with current epoch and PC.
//  Response: cycle after issue, if tag epoch == epoch, write {IMemData, PC} at tail; otherwise drop.
//  Dequeue: deq pops head on clock edge; simultaneous push+pop keeps count unchanged (legal when full).
//  Redirect (highest priority, overrides StallD): next edge count=0, head=tail=0, epoch toggles,
//   FetchPC=RedirectPC, ValidD=0; any in-flight response arriving next cycle is dropped (epoch mismatch).
//   Fetch of RedirectPC issues the cycle after RedirectE. Redirect during reset ignored.
//  Latency (no bypass): redirect -> ValidD with target = 3 cycles.
//  ValidD = (count != 0). Outputs are registered head-entry fields; no combinational path from StallD.
//  FSM: RUN (issuing when credit allows) / HOLD (credit exhausted; IMemRd=0). RUN->HOLD when
//   credit reaches DEPTH; HOLD->RUN on deq or RedirectE. Pointers wrap modulo DEPTH.
//  RedirectPC[1:0] ignored (forced 00). FetchPC wraps 32'hFFFF_FFFC -> 0.
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: when count==0 and a matching-epoch response arrives, it drives
//   InstrD/PCD/ValidD combinationally that cycle; if not dequeued it is also written to the queue.
//   Redirect-to-ValidD latency becomes 2 cycles.
//  Undefined: responses always enter the queue; visible to decode one cycle later.
// STRUCTURE
//  Parameters.v gains `NOP_INSTR (32'h0000_0013) and field-slice macros `OP_FIELD/`FN3_FIELD/`FN7_FIELD.
//  One sub-module: fetchq_fifo (DEPTH x 64-bit circular buffer, push/pop/clear, count, head data).
//  Top holds FetchPC, epoch, in-flight tag, credit logic and RUN/HOLD FSM.
// TESTING
//  Reset release, StallD=0, IMem returns addr-as-data -> PCD 0,4,8,... one per cycle, ValidD from cycle 3.
//  StallD=1 for 6 cycles -> count saturates at 4, IMemRd=0 (HOLD), PCD frozen; release -> no gap, no dup.
//  RedirectE with RedirectPC=0x100 while full and inflight -> next ValidD=1 carries PCD=0x100, no stale PC.
//  Redirect and StallD same cycle -> redirect wins; queue empty next edge.
//  Back-to-back redirects (0x200 then 0x300) -> only 0x300 stream appears, 0x200 word dropped.
//  rst asserted mid-stream -> all outputs return to reset values immediately (async); restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants, entry layout and decoder field slices for the instruction-fetch queue.
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [6:0] op_field(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] fn3_field(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [6:0] fn7_field(input logic [31:0] instr);
    return instr[31:25];
  endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// DEPTH x 64-bit circular buffer holding {instr, pc} entries; push/pop/clear with occupancy count.
module fetchq_fifo #(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [63:0]   wdata,
  output logic [CW-1:0] count,
  output logic [63:0]   rdata
);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wdata;
  end

  assign rdata = mem[head];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: sequential PC issue to a 1-cycle BRAM, credit-limited queue, epoch-based flush.
// Optional build macro FETCHQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddr,
  output logic        IMemRd,
  input  logic [31:0] IMemData,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [6:0]  OpD,
  output logic [2:0]  Fn3D,
  output logic [6:0]  Fn7D
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          epoch;
  logic          inflight;
  logic          inflight_epoch;
  logic [31:0]   inflight_pc;
  logic [0:0]    state;

  logic [CW-1:0] count;
  logic [63:0]   head_data;
  fetch_entry_t  head;
  logic          fifo_valid;
  logic          resp_ok;
  logic          bypass;
  logic          deq;
  logic          push;
  logic          pop;
  logic [CW:0]   occ_next;
  logic [31:0]   redirect_target;

  assign head            = head_data;
  assign fifo_valid      = (count != '0);
  assign resp_ok         = inflight && (inflight_epoch == epoch);
  assign redirect_target = RedirectPC & ~32'h3;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = !fifo_valid && resp_ok;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    ValidD = fifo_valid || bypass;
    InstrD = NOP_INSTR;
    PCD    = '0;
    if (bypass) begin
      InstrD = IMemData;
      PCD    = inflight_pc;
    end else if (fifo_valid) begin
      InstrD = head.instr;
      PCD    = head.pc;
    end
  end

  assign OpD  = op_field(InstrD);
  assign Fn3D = fn3_field(InstrD);
  assign Fn7D = fn7_field(InstrD);

  // A bypassed word that decode consumes this cycle never needs a queue slot.
  assign deq  = ValidD && !StallD;
  assign pop  = deq && fifo_valid && !RedirectE;
  assign push = resp_ok && !RedirectE && !(bypass && deq);

  // HOLD means queued + in-flight words already fill every slot, so only a dequeue frees credit.
  assign IMemRd   = !rst && !RedirectE && ((state == ST_RUN) || deq);
  assign IMemAddr = fetch_pc;
  assign occ_next = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop) + (CW + 1)'(IMemRd);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
      state          <= ST_RUN;
    end else if (RedirectE) begin
      fetch_pc <= redirect_target;
      epoch    <= ~epoch;
      inflight <= 1'b0;
      state    <= ST_RUN;
    end else begin
      inflight <= IMemRd;
      if (IMemRd) begin
        fetch_pc       <= fetch_pc + 32'd4;
        inflight_epoch <= epoch;
        inflight_pc    <= fetch_pc;
      end
      state <= (occ_next == DEPTH_C) ? ST_HOLD : ST_RUN;
    end
  end

  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (RedirectE),
    .push  (push),
    .pop   (pop),
    .wdata ({IMemData, inflight_pc}),
    .count (count),
    .rdata (head_data)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, stall/HOLD, redirects, PC wrap and async reset.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        StallD;
  logic        RedirectE;
  logic [31:0] RedirectPC;
  logic [31:0] IMemAddr;
  logic        IMemRd;
  logic [31:0] IMemData;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [6:0]  OpD;
  logic [2:0]  Fn3D;
  logic [6:0]  Fn7D;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallD     (StallD),
    .RedirectE  (RedirectE),
    .RedirectPC (RedirectPC),
    .IMemAddr   (IMemAddr),
    .IMemRd     (IMemRd),
    .IMemData   (IMemData),
    .ValidD     (ValidD),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .OpD        (OpD),
    .Fn3D       (Fn3D),
    .Fn7D       (Fn7D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns its own address as data, one cycle after the read.
  initial IMemData = 32'h0;
  always @(posedge clk) begin
    if (IMemRd) IMemData <= IMemAddr;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, 32'(ValidD), 32'd1);
    check({tag, " pc"}, PCD, pc);
    check({tag, " instr"}, InstrD, pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, 32'(ValidD), 32'd0);
    check({tag, " instr"}, InstrD, 32'h0000_0013);
    check({tag, " pc"}, PCD, 32'd0);
    check({tag, " rd"}, 32'(IMemRd), 32'd0);
    check({tag, " addr"}, IMemAddr, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    StallD     = 1'b0;
    RedirectE  = 1'b0;
    RedirectPC = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Cycle 0: first fetch right after reset release.
    rst = 1'b0;
    #1;
    check("c0 rd", 32'(IMemRd), 32'd1);
    check("c0 addr", IMemAddr, 32'd0);
    @(negedge clk);
    check("c1 valid", 32'(ValidD), 32'd0);
    check("c1 addr", IMemAddr, 32'd4);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check_head($sformatf("stream c%0d", k), 32'(4 * (k - 2)));
    end

    // Stall the head (PC 12) for six edges; queue fills and fetch goes to HOLD.
    StallD = 1'b1;
    #1;
    check("c5 rd", 32'(IMemRd), 32'd1);
    for (int k = 6; k <= 11; k++) begin
      @(negedge clk);
      check_head($sformatf("stall c%0d", k), 32'd12);
      if (k >= 7) check($sformatf("hold c%0d rd", k), 32'(IMemRd), 32'd0);
    end
    StallD = 1'b0;
    #1;
    check("release rd", 32'(IMemRd), 32'd1);
    check("release addr", IMemAddr, 32'd28);
    for (int k = 12; k <= 16; k++) begin
      @(negedge clk);
      check_head($sformatf("resume c%0d", k), 32'(16 + 4 * (k - 12)));
    end

    // Redirect with a stall in the same cycle, queue holding words and a response in flight.
    StallD     = 1'b1;
    RedirectE  = 1'b1;
    RedirectPC = 32'h0000_0103;
    #1;
    check("redir rd", 32'(IMemRd), 32'd0);
    @(negedge clk);
    check("redir c17 valid", 32'(ValidD), 32'd0);
    check("redir c17 instr", InstrD, 32'h0000_0013);
    RedirectE = 1'b0;
    StallD    = 1'b0;
    #1;
    check("redir c17 rd", 32'(IMemRd), 32'd1);
    check("redir c17 addr", IMemAddr, 32'h100);
    @(negedge clk);
    check("redir c18 valid", 32'(ValidD), 32'd0);
    @(negedge clk);
    check_head("redir c19", 32'h100);
    @(negedge clk);
    check_head("redir c20", 32'h104);

    // Back-to-back redirects: only the second target stream may appear.
    RedirectE  = 1'b1;
    RedirectPC = 32'h200;
    @(negedge clk);
    RedirectPC = 32'h300;
    check("b2b c21 valid", 32'(ValidD), 32'd0);
    @(negedge clk);
    RedirectE = 1'b0;
    #1;
    check("b2b c22 rd", 32'(IMemRd), 32'd1);
    check("b2b c22 addr", IMemAddr, 32'h300);
    @(negedge clk);
    check("b2b c23 valid", 32'(ValidD), 32'd0);
    @(negedge clk);
    check_head("b2b c24", 32'h300);
    @(negedge clk);
    check_head("b2b c25", 32'h304);

    // Fetch PC wraps from the top of the address space back to zero.
    RedirectE  = 1'b1;
    RedirectPC = 32'hFFFF_FFF8;
    @(negedge clk);
    RedirectE = 1'b0;
    repeat (2) @(negedge clk);
    check_head("wrap c28", 32'hFFFF_FFF8);
    @(negedge clk);
    check_head("wrap c29", 32'hFFFF_FFFC);
    check("fields op", 32'(OpD), 32'h7C);
    check("fields fn3", 32'(Fn3D), 32'h7);
    check("fields fn7", 32'(Fn7D), 32'h7F);
    @(negedge clk);
    check_head("wrap c30", 32'h0);
    @(negedge clk);
    check_head("wrap c31", 32'h4);

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("restart rd", 32'(IMemRd), 32'd1);
    check("restart addr", IMemAddr, 32'd0);
    repeat (2) @(negedge clk);
    check_head("restart c2", 32'd0);
    @(negedge clk);
    check_head("restart c3", 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
